// File: rtl/ps2_event_decoder_pkg.sv
// Shared PS/2 byte constants, decoder state encoding and the 10-bit key event word.
// Imported by the decoder top and its event FIFO.
package ps2_event_decoder_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam logic [7:0] PS2_BAT   = 8'hAA;
   localparam logic [7:0] PS2_ACK   = 8'hFA;
   localparam logic [7:0] PS2_ECHO  = 8'hEE;
   localparam logic [7:0] PS2_OVR0  = 8'h00;
   localparam logic [7:0] PS2_OVR1  = 8'hFF;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_EXT     = 3'd1;
   localparam logic [2:0] ST_BRK     = 3'd2;
   localparam logic [2:0] ST_EXT_BRK = 3'd3;
   localparam logic [2:0] ST_PAUSE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      EXT     = ST_EXT,
      BRK     = ST_BRK,
      EXT_BRK = ST_EXT_BRK,
      PAUSE   = ST_PAUSE
   } state_t;

   // Pause is E1 followed by seven more bytes that carry no extra information.
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam int EV_W = 10;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ev_t;

   // True for a byte that, received in IDLE, is a plain make code.
   function automatic logic idle_is_make(input logic [7:0] b);
      return !(b == PS2_EXT  || b == PS2_BRK || b == PS2_PAUSE ||
               b == PS2_BAT  || b == PS2_ACK || b == PS2_ECHO  ||
               b == PS2_OVR0 || b == PS2_OVR1);
   endfunction

endpackage

// File: rtl/ps2_event_decoder_ev_fifo.sv
// Show-ahead DEPTH x W FIFO; dout is the head entry combinationally, write visible next cycle.
// A push while full is accepted only together with a pop; pop on empty is ignored.
module ev_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   // Storage is reset too so the head outputs read zero straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
            wptr              <= wptr + (AW+1)'(1);
         end
         if (do_pop) rptr <= rptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ps2_event_decoder.sv
// PS/2 byte stream to {ext, brk, code} key events; event visible one cycle after its last byte.
// Events queue in a show-ahead FIFO; when full without a pop the event is dropped and overflow sticks.
module ps2_event_decoder
   import ps2_event_decoder_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_brk,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic       kbd_err,
   output logic       overflow
);

   localparam int             TW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [2:0]    skip;
   logic [TW-1:0] idle_cnt;

   logic          byte_ok;
   logic          push_req;
   ev_t           push_ev;
   ev_t           head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;

   assign byte_ok  = rx_valid & ~rx_err;
   assign ev_valid = ~fifo_empty;
   assign pop      = ev_valid & ev_ready;
   assign ev_code  = head.code;
   assign ev_ext   = head.ext;
   assign ev_brk   = head.brk;

   // Event decode is combinational so the push lands on the same edge as the final byte.
   always_comb begin
      push_req     = 1'b0;
      push_ev      = '0;
      push_ev.code = rx_byte;
      if (byte_ok) begin
         case (state)
            IDLE:    push_req = idle_is_make(rx_byte);
            EXT: begin
               push_req    = (rx_byte != PS2_BRK);
               push_ev.ext = 1'b1;
            end
            BRK: begin
               push_req    = 1'b1;
               push_ev.brk = 1'b1;
            end
            EXT_BRK: begin
               push_req    = 1'b1;
               push_ev.ext = 1'b1;
               push_ev.brk = 1'b1;
            end
            PAUSE: begin
               push_req     = (skip == 3'd1);
               push_ev.code = PS2_PAUSE;
            end
            default: push_req = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         skip     <= '0;
         idle_cnt <= '0;
         kbd_err  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         kbd_err <= 1'b0;
         if (push_req && fifo_full && !pop) overflow <= 1'b1;

         if (rx_valid) begin
            idle_cnt <= '0;
            if (rx_err) begin
               state   <= IDLE;
               kbd_err <= 1'b1;
            end else begin
               case (state)
                  IDLE: begin
                     case (rx_byte)
                        PS2_EXT:   state <= EXT;
                        PS2_BRK:   state <= BRK;
                        PS2_PAUSE: begin
                           state <= PAUSE;
                           skip  <= PAUSE_SKIP;
                        end
                        PS2_OVR0, PS2_OVR1: kbd_err <= 1'b1;
                        default: state <= IDLE;
                     endcase
                  end
                  EXT:     state <= (rx_byte == PS2_BRK) ? EXT_BRK : IDLE;
                  PAUSE: begin
                     skip <= skip - 3'd1;
                     if (skip == 3'd1) state <= IDLE;
                  end
                  default: state <= IDLE;
               endcase
            end
         end else if (state != IDLE) begin
            // A prefix left hanging too long is abandoned so the next byte starts clean.
            if (idle_cnt == TO_LAST) begin
               state    <= IDLE;
               kbd_err  <= 1'b1;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + TW'(1);
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   ev_fifo #(
      .DEPTH (DEPTH),
      .W     (EV_W)
   ) u_ev_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (push_ev),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_ps2_event_decoder.sv
// Bench for ps2_event_decoder: directed key sequences plus random byte streams against a
// queue-based model of the key-event rules.
module tb_ps2_event_decoder;

   localparam int DEPTH = 4;
   localparam int TO    = 20;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic [7:0] rx_byte  = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err   = 1'b0;
   logic       ev_ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_brk;
   logic       ev_valid;
   logic       kbd_err;
   logic       overflow;

   ps2_event_decoder #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .ev_code  (ev_code),
      .ev_ext   (ev_ext),
      .ev_brk   (ev_brk),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .kbd_err  (kbd_err),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending prefix flags, expected event queue, expected error/overflow.
   logic [9:0] q[$];
   bit         m_ext;
   bit         m_brk;
   int         m_pause;
   bit         m_err;
   bit         m_ovf;
   int         cyc;
   int         last_strobe;

   task automatic model_reset();
      q.delete();
      m_ext   = 0;
      m_brk   = 0;
      m_pause = 0;
      m_err   = 0;
      m_ovf   = 0;
   endtask

   task automatic model_step();
      bit         pop;
      bit         push;
      bit         err;
      logic [9:0] ev;
      pop  = (q.size() > 0) && ev_ready;
      push = 0;
      err  = 0;
      ev   = '0;
      if (rx_valid) begin
         last_strobe = cyc;
         if (rx_err) begin
            err = 1; m_ext = 0; m_brk = 0; m_pause = 0;
         end else if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin push = 1; ev = {2'b00, 8'hE1}; end
         end else if (m_brk) begin
            push = 1; ev = {m_ext, 1'b1, rx_byte}; m_ext = 0; m_brk = 0;
         end else if (m_ext && rx_byte != 8'hF0) begin
            push = 1; ev = {2'b10, rx_byte}; m_ext = 0;
         end else if (rx_byte == 8'hF0) m_brk = 1;
         else if (rx_byte == 8'hE0) m_ext = 1;
         else if (rx_byte == 8'hE1) m_pause = 7;
         else if (rx_byte inside {8'hAA, 8'hFA, 8'hEE}) err = 0;
         else if (rx_byte inside {8'h00, 8'hFF}) err = 1;
         else begin push = 1; ev = {2'b00, rx_byte}; end
      end else if ((m_ext || m_brk || m_pause > 0) && (cyc - last_strobe == TO)) begin
         err = 1; m_ext = 0; m_brk = 0; m_pause = 0;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(ev);
         else m_ovf = 1;
      end
      m_err = err;
      cyc++;
   endtask

   task automatic check_outputs();
      check_eq("ev_valid", ev_valid, q.size() > 0);
      if (q.size() > 0) check_eq("head_event", {ev_ext, ev_brk, ev_code}, q[0]);
      check_eq("kbd_err", kbd_err, m_err);
      check_eq("overflow", overflow, m_ovf);
   endtask

   // One clock: drive inputs, check outputs of the previous edge, advance model, take the edge.
   task automatic cycle(input logic v, input logic [7:0] b, input logic e, input int rdy_pct);
      rx_valid = v;
      rx_byte  = b;
      rx_err   = e;
      ev_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic idle(input int n, input int rdy_pct);
      repeat (n) cycle(1'b0, 8'h00, 1'b0, rdy_pct);
   endtask

   task automatic send(input logic [7:0] b, input logic e, input int gap, input int rdy_pct);
      cycle(1'b1, b, e, rdy_pct);
      idle(gap - 1, rdy_pct);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rx_err   = 1'b0;
      reset    = 1'b1;
      #2;
      check_eq("rst_ev_valid", ev_valid, 0);
      check_eq("rst_ev_code", ev_code, 0);
      check_eq("rst_ev_ext", ev_ext, 0);
      check_eq("rst_ev_brk", ev_brk, 0);
      check_eq("rst_kbd_err", kbd_err, 0);
      check_eq("rst_overflow", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
   logic [7:0] makes     [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

   initial begin
      cyc = 0;
      last_strobe = 0;
      model_reset();
      do_reset();

      // single make, then extended/break sequences
      send(8'h1C, 0, 3, 100);
      send(8'hF0, 0, 2, 100);
      send(8'h1C, 0, 2, 100);
      send(8'hE0, 0, 2, 100);
      send(8'hF0, 0, 2, 100);
      send(8'h75, 0, 3, 100);

      // Pause with status bytes around it
      send(8'hAA, 0, 2, 100);
      foreach (pause_seq[i]) send(pause_seq[i], 0, 2, 100);
      send(8'hFA, 0, 2, 100);
      send(8'hEE, 0, 3, 100);

      // overflow with consumer stalled, then drain
      foreach (makes[i]) send(makes[i], 0, 2, 0);
      idle(8, 100);

      // prefix timeout, then a plain make
      send(8'hE0, 0, TO + 3, 100);
      send(8'h6B, 0, 3, 100);

      // errored byte in a break sequence
      send(8'hF0, 0, 2, 100);
      send(8'h1C, 1, 3, 100);

      // overrun bytes and timeout boundary (exactly TO and TO+1 idle cycles)
      send(8'h00, 0, 2, 100);
      send(8'hFF, 0, 2, 100);
      send(8'hE0, 0, TO, 100);
      send(8'h70, 0, 2, 100);
      send(8'hE0, 0, TO + 1, 100);
      send(8'h70, 0, 3, 100);

      // reset in the middle of an extended sequence
      do_reset();
      send(8'hE0, 0, 2, 100);
      do_reset();
      send(8'h74, 0, 4, 100);

      // random streams at several consumer speeds
      for (int blk = 0; blk < 3; blk++) begin
         int pct;
         pct = (blk == 0) ? 90 : (blk == 1) ? 40 : 70;
         do_reset();
         for (int i = 0; i < 250; i++) begin
            logic [7:0] b;
            logic       e;
            int         g;
            int         r;
            r = $urandom_range(0, 15);
            case (r)
               0:       b = 8'hE0;
               1, 2:    b = 8'hF0;
               3:       b = 8'hE1;
               4:       begin
                  b = 8'hAA;
                  if ($urandom_range(0, 2) == 1) b = 8'hFA;
                  else if ($urandom_range(0, 1) == 1) b = 8'hEE;
               end
               5:       b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
               default: b = 8'($urandom_range(0, 255));
            endcase
            e = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 11);
            if (r == 0)      g = TO;
            else if (r == 1) g = TO + 1;
            else if (r == 2) g = TO + $urandom_range(2, 10);
            else             g = $urandom_range(1, 3);
            send(b, e, g, pct);
         end
         idle(TO + 10, 100);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_event_decoder.md
Name: ps2_event_decoder

Overview:
- Sits between the PS/2 byte receiver and display/command logic.
- Consumes every received PS/2 byte and tracks the E0 (extended), F0 (release) and E1 (Pause) prefix sequences.
- Emits complete key events {ext, brk, code} into a small show-ahead FIFO with a valid/ready interface.
- Supplies make and break events, so consumers no longer see only releases.

Parameters:
- DEPTH, 4: event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000: idle cycles after a prefix byte before the partial sequence is abandoned (2 ms at 25 MHz).

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  reset, asynchronous, active-high; clock clk.
- rx_byte  in  8  received data byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- rx_err  in  1  parity/framing error for the byte strobed this cycle.
- ev_code  out  8  scancode of the head event.
- ev_ext  out  1  head event had an E0 prefix.
- ev_brk  out  1  head event is a release (F0 seen).
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer accepts the head event this cycle.
- kbd_err  out  1  one-cycle pulse on an rx_err byte, overrun byte (00/FF), or prefix timeout.
- overflow  out  1  sticky; set when an event is dropped with the FIFO full; cleared only by reset.

Behaviour:
- Reset values: ev_valid=0, ev_code=0, ev_ext=0, ev_brk=0, kbd_err=0, overflow=0. FSM=IDLE, FIFO empty, timeout counter=0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0), PAUSE (E1 seen).
- Bytes are evaluated only when rx_valid=1.
- IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter=7.
  - AA, FA, EE -> ignored, stay IDLE.
  - 00, FF -> kbd_err pulse, stay IDLE.
  - Any other byte -> push {ext=0, brk=0, code}, stay IDLE.
- EXT: F0 -> EXT_BRK; any other byte -> push {1, 0, code}, go IDLE.
- BRK: push {0, 1, code}, go IDLE.
- EXT_BRK: push {1, 1, code}, go IDLE.
- PAUSE:
  - Each byte decrements the skip counter; contents are not checked.
  - When the counter reaches 0 (the 7th byte after E1), push {0, 0, E1} and go IDLE.
  - Pause therefore yields exactly one make event with code E1.
- rx_err=1 with rx_valid: byte discarded, kbd_err pulse, FSM to IDLE from any state, no push.
- Timeout:
  - Counter clears on every rx_valid and counts while the FSM is not IDLE.
  - At TIMEOUT_CYCLES-1 the FSM returns to IDLE, kbd_err pulses, no push.
  - Counter width: clog2(TIMEOUT_CYCLES).
- kbd_err is registered, asserted the cycle after the triggering event.
- Latency: final byte strobed at cycle N -> event on the ev_* outputs with ev_valid=1 at N+1 if the FIFO was empty.
- FIFO:
  - Show-ahead; ev_* always reflect the head entry.
  - Pop when ev_valid & ev_ready.
  - Push accepted when not full, or when full with a pop in the same cycle.
  - Push while full without a pop: event dropped, overflow<=1, FSM still advances to IDLE.
  - Simultaneous push and pop on an empty FIFO: no pop occurs (ev_valid=0); the push lands.
  - Pointers are log2(DEPTH)+1 bits wide; full/empty from MSB comparison; wrap-around is natural.
- Reset mid-sequence abandons any partial prefix and empties the FIFO; no event is emitted for the partial sequence.

Decomposition:
- Shared package holds:
  - Byte constants: PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_ECHO=EE, PS2_OVR0=00, PS2_OVR1=FF.
  - State encoding: 3-bit localparams IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - Event word layout: 10 bits {ext, brk, code[7:0]}.
- One sub-module: ev_fifo (parameterised DEPTH x 10-bit show-ahead synchronous FIFO, ports push/pop/din/dout/full/empty).
- Decoder FSM and timeout stay in the top module.

Test Plan:
- Make 1C, ev_ready=1 -> one event {ext=0, brk=0, code=1C}, ev_valid high one cycle after the strobe, then low.
- Bytes F0 1C, then E0 F0 75 -> events {0,1,1C} then {1,1,75}, in order; no event for the prefix bytes.
- Pause E1 14 77 E1 F0 14 F0 77 -> exactly one event {0,0,E1} after the 8th byte; AA, FA, EE interleaved in IDLE produce nothing.
- ev_ready=0, five makes 16,1E,26,25,2E with DEPTH=4 -> overflow=1 after the 5th; drain yields 16,1E,26,25; overflow stays 1.
- E0 then silence for TIMEOUT_CYCLES -> kbd_err single pulse, FSM IDLE; a following 6B emits {0,0,6B}, not extended.
- F0 followed by 1C with rx_err=1 -> kbd_err pulse, no event. Separately: async reset asserted between E0 and 74 -> after release, 74 emits {0,0,74} and outputs were all 0 during reset.
